// File: rtl/cskipa_io_stage.sv
// Two-stage valid/ready wrapper around an external carry-skip adder.
// Stage A registers the operand pair and drives the adder directly from flops;
// stage B captures the combinational sum/carry and holds it for the consumer.
// Two statistics counters track delivered results and delivered carries.
module cskipa_io_stage #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    // Operand side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    // Adder side
    output logic [WIDTH-1:0] add_term1,
    output logic [WIDTH-1:0] add_term2,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    // Result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    // Statistics
    output logic [CNT_W-1:0] res_count,
    output logic [CNT_W-1:0] cout_count
);

    // Stage A state
    logic             r_a_valid;
    logic [WIDTH-1:0] r_a_op1;
    logic [WIDTH-1:0] r_a_op2;

    // Stage B state
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;

    // Counters
    logic [CNT_W-1:0] r_res_count;
    logic [CNT_W-1:0] r_cout_count;

    // Handshake decode
    logic w_b_load;
    logic w_in_accept;
    logic w_out_xfer;
    logic w_res_sat;
    logic w_cout_sat;

    // Stage B can take a new result when empty or when it is being drained now.
    // clr freezes all data movement, so every transfer below is gated by it.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        w_b_load    = 1'b0;
        w_in_accept = 1'b0;
        w_out_xfer  = 1'b0;
        in_ready    = 1'b0;
        if (!clr) begin
            w_b_load    = r_a_valid && (!r_out_valid || out_ready);
            in_ready    = !r_a_valid || w_b_load;
            w_in_accept = in_valid && in_ready;
            w_out_xfer  = r_out_valid && out_ready;
        end
    end

    assign w_res_sat  = &r_res_count;
    assign w_cout_sat = &r_cout_count;

    // Stage A: load new operands on accept, otherwise hold; valid drops once the pair moves to B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state is updated with non-blocking assignments so all flops sample the same edge values.
            r_a_valid <= 1'b0;
            r_a_op1   <= '0;
            r_a_op2   <= '0;
        end else if (clr) begin
            r_a_valid <= 1'b0;
        end else if (w_in_accept) begin
            r_a_valid <= 1'b1;
            r_a_op1   <= in_a;
            r_a_op2   <= in_b;
        end else if (w_b_load) begin
            r_a_valid <= 1'b0;
        end
    end

    // Stage B: capture the adder result on b_load, drop valid after a drain with no refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
        end else if (w_b_load) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= add_sum;
            r_out_cout  <= add_cout;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Statistics: count delivered results and carries, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_count  <= '0;
            r_cout_count <= '0;
        end else if (clr) begin
            r_res_count  <= '0;
            r_cout_count <= '0;
        end else if (w_out_xfer) begin
            if (!w_res_sat) begin
                r_res_count <= r_res_count + 1'b1;
            end
            if (r_out_cout && !w_cout_sat) begin
                r_cout_count <= r_cout_count + 1'b1;
            end
        end
    end

    // The adder is fed straight from stage A flops, so its inputs hold when stage A empties.
    assign add_term1  = r_a_op1;
    assign add_term2  = r_a_op2;
    assign out_valid  = r_out_valid;
    assign out_sum    = r_out_sum;
    assign out_cout   = r_out_cout;
    assign res_count  = r_res_count;
    assign cout_count = r_cout_count;

endmodule

// File: tb/tb_cskipa_io_stage.sv
// Directed bench for cskipa_io_stage with a behavioural adder model.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_cskipa_io_stage;

    localparam int WIDTH = 12;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] add_term1;
    logic [WIDTH-1:0] add_term2;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [CNT_W-1:0] res_count;
    logic [CNT_W-1:0] cout_count;

    int n_checks = 0;
    int n_errors = 0;

    cskipa_io_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_term1  (add_term1),
        .add_term2  (add_term2),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .res_count  (res_count),
        .cout_count (cout_count)
    );

    // Adder model: carry-in is 0
    assign {add_cout, add_sum} = {1'b0, add_term1} + {1'b0, add_term2};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] held;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_cout_count", 32'(cout_count), 32'd0);
        check("rst_term1", 32'(add_term1), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Basic latency: 0xFFF + 0x001
        out_ready = 1'b1;
        drive(1'b1, 12'hFFF, 12'h001);
        check("lat_in_ready_first", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 12'h000, 12'h000);
        check("lat_valid_n", 32'(out_valid), 32'd0);
        step();
        check("lat_valid_n1", 32'(out_valid), 32'd1);
        check("lat_sum", 32'(out_sum), 32'h000);
        check("lat_cout", 32'(out_cout), 32'd1);
        step();
        check("lat_res_count", 32'(res_count), 32'd1);
        check("lat_cout_count", 32'(cout_count), 32'd1);
        check("lat_valid_drop", 32'(out_valid), 32'd0);
        check("hold_term1", 32'(add_term1), 32'hFFF);
        check("hold_term2", 32'(add_term2), 32'h001);

        // Streaming, back-to-back
        do_clr();
        check("clr_res_count", 32'(res_count), 32'd0);
        drive(1'b1, 12'h800, 12'h7FF);
        step();
        drive(1'b1, 12'h555, 12'hAAA);
        check("str_in_ready", 32'(in_ready), 32'd1);
        step();
        check("str_sum0", 32'(out_sum), 32'hFFF);
        check("str_cout0", 32'(out_cout), 32'd0);
        drive(1'b1, 12'h123, 12'h456);
        step();
        drive(1'b0, 12'h000, 12'h000);
        check("str_valid1", 32'(out_valid), 32'd1);
        check("str_sum1", 32'(out_sum), 32'hFFF);
        step();
        check("str_valid2", 32'(out_valid), 32'd1);
        check("str_sum2", 32'(out_sum), 32'h579);
        check("str_cout2", 32'(out_cout), 32'd0);
        step();
        check("str_res_count", 32'(res_count), 32'd3);
        check("str_cout_count", 32'(cout_count), 32'd0);

        // Backpressure: two accepts, then stall
        do_clr();
        out_ready = 1'b0;
        drive(1'b1, 12'h100, 12'h011);
        step();
        drive(1'b1, 12'h200, 12'h022);
        check("bp_in_ready_2nd", 32'(in_ready), 32'd1);
        step();
        drive(1'b1, 12'h300, 12'h033);
        check("bp_first_sum", 32'(out_sum), 32'h111);
        for (int i = 0; i < 4; i++) begin
            check("bp_in_ready_stall", 32'(in_ready), 32'd0);
            check("bp_sum_held", 32'(out_sum), 32'h111);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            step();
        end
        drive(1'b0, 12'h000, 12'h000);
        out_ready = 1'b1;
        #1;
        check("bp_release_sum", 32'(out_sum), 32'h111);
        step();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_sum", 32'(out_sum), 32'h222);
        step();
        check("bp_drain_valid", 32'(out_valid), 32'd0);
        check("bp_res_count", 32'(res_count), 32'd2);

        // Reset mid-operation with two transactions in flight
        out_ready = 1'b0;
        drive(1'b1, 12'h0AB, 12'h001);
        step();
        drive(1'b1, 12'h0CD, 12'h001);
        step();
        drive(1'b0, 12'h000, 12'h000);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_res_count", 32'(res_count), 32'd0);
        check("mrst_cout_count", 32'(cout_count), 32'd0);
        check("mrst_out_sum", 32'(out_sum), 32'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 12'h001, 12'h001);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 12'h000, 12'h000);
        check("mrst_no_ghost", 32'(out_valid), 32'd0);
        step();
        check("mrst_valid", 32'(out_valid), 32'd1);
        check("mrst_sum", 32'(out_sum), 32'h002);
        step();
        check("mrst_res_count_after", 32'(res_count), 32'd1);

        // clr priority over handshakes
        out_ready = 1'b0;
        drive(1'b1, 12'h010, 12'h020);
        step();
        drive(1'b1, 12'h040, 12'h050);
        step();
        check("clr_setup_valid", 32'(out_valid), 32'd1);
        held = out_sum;
        check("clr_setup_sum", 32'(held), 32'h030);
        out_ready = 1'b1;
        clr = 1'b1;
        #1;
        check("clr_in_ready", 32'(in_ready), 32'd0);
        step();
        clr = 1'b0;
        drive(1'b0, 12'h000, 12'h000);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_res_count", 32'(res_count), 32'd0);
        check("clr_sum_kept", 32'(out_sum), 32'(held));
        check("clr_term1_kept", 32'(add_term1), 32'h040);
        step();
        check("clr_a_flushed", 32'(out_valid), 32'd0);
        check("clr_res_count2", 32'(res_count), 32'd0);

        // Saturation: 20 results of 0xFFF + 0xFFF
        drive(1'b1, 12'hFFF, 12'hFFF);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        drive(1'b0, 12'h000, 12'h000);
        step();
        step();
        check("sat_res_count", 32'(res_count), 32'hF);
        check("sat_cout_count", 32'(cout_count), 32'hF);
        check("sat_sum", 32'(out_sum), 32'hFFE);
        check("sat_cout", 32'(out_cout), 32'd1);
        check("sat_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
